// File: rtl/stream_check.sv
// AXI4-Stream sink that checks frames carry an incrementing-index payload, correct tlast placement and full tkeep.
// Counters and frame_done update on the edge of the beat; tready is a free-running 1-in-(ready_rate+1) pulse that ignores tvalid.
module stream_check (
  input  logic        clk,
  input  logic        aresetn,
  input  logic        clr,
  input  logic [31:0] frame_size,
  input  logic [15:0] ready_rate,
  input  logic [31:0] tdata,
  input  logic [3:0]  tkeep,
  input  logic        tlast,
  input  logic        tvalid,
  output logic        tready,
  output logic [31:0] frame_count,
  output logic [15:0] data_err_count,
  output logic [15:0] last_err_count,
  output logic [15:0] keep_err_count,
  output logic        frame_done,
  output logic        error
);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] idx_q, idx_d;
  logic [31:0] len_q, len_d;
  logic [15:0] bp_cnt_q, bp_cnt_d;
  logic        tready_q, tready_d;
  logic [31:0] frame_count_q, frame_count_d;
  logic [15:0] data_err_q, data_err_d;
  logic [15:0] last_err_q, last_err_d;
  logic [15:0] keep_err_q, keep_err_d;
  logic        frame_done_q, frame_done_d;
  logic        error_q, error_d;

  logic        beat;
  logic [31:0] n_cur;
  logic        last_pos;
  logic        data_bad, keep_bad, short_err, long_err;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign beat = tvalid & tready_q;

  // bp_cnt_q holds the low cycles still owed; ready_rate is only sampled on the high cycle.
  always_comb begin
    tready_d = 1'b0;
    bp_cnt_d = bp_cnt_q;
    if (bp_cnt_q == 16'd0) begin
      tready_d = 1'b1;
      bp_cnt_d = ready_rate;
    end else begin
      bp_cnt_d = bp_cnt_q - 16'd1;
    end
  end

  // Frame length is taken live from frame_size on the first beat, then held in len_q.
  assign n_cur    = (idx_q == 32'd0) ? ((frame_size == 32'd0) ? 32'd1 : frame_size) : len_q;
  assign last_pos = (idx_q == n_cur - 32'd1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    len_d         = len_q;
    frame_count_d = frame_count_q;
    data_err_d    = data_err_q;
    last_err_d    = last_err_q;
    keep_err_d    = keep_err_q;
    frame_done_d  = 1'b0;
    error_d       = error_q;
    data_bad      = 1'b0;
    keep_bad      = 1'b0;
    short_err     = 1'b0;
    long_err      = 1'b0;

    if (clr) begin
      state_d       = S_RUN;
      idx_d         = 32'd0;
      frame_count_d = 32'd0;
      data_err_d    = 16'd0;
      last_err_d    = 16'd0;
      keep_err_d    = 16'd0;
      error_d       = 1'b0;
    end else if (beat) begin
      keep_bad = (tkeep != 4'hF);
      if (state_q == S_RUN) begin
        len_d    = n_cur;
        data_bad = (tdata != idx_q);
        if (tlast) begin
          idx_d = 32'd0;
          if (last_pos) begin
            frame_count_d = frame_count_q + 32'd1;
            frame_done_d  = 1'b1;
          end else begin
            short_err = 1'b1;
          end
        end else if (last_pos) begin
          long_err = 1'b1;
          state_d  = S_FLUSH;
        end else begin
          idx_d = idx_q + 32'd1;
        end
      end else if (tlast) begin
        idx_d   = 32'd0;
        state_d = S_RUN;
      end

      if (data_bad)             data_err_d = sat_inc(data_err_q);
      if (keep_bad)             keep_err_d = sat_inc(keep_err_q);
      if (short_err | long_err) last_err_d = sat_inc(last_err_q);
      if (data_bad | keep_bad | short_err | long_err) error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_RUN;
      idx_q         <= 32'd0;
      len_q         <= 32'd1;
      bp_cnt_q      <= 16'd0;
      tready_q      <= 1'b0;
      frame_count_q <= 32'd0;
      data_err_q    <= 16'd0;
      last_err_q    <= 16'd0;
      keep_err_q    <= 16'd0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      len_q         <= len_d;
      bp_cnt_q      <= bp_cnt_d;
      tready_q      <= tready_d;
      frame_count_q <= frame_count_d;
      data_err_q    <= data_err_d;
      last_err_q    <= last_err_d;
      keep_err_q    <= keep_err_d;
      frame_done_q  <= frame_done_d;
      error_q       <= error_d;
    end
  end

  assign tready         = tready_q;
  assign frame_count    = frame_count_q;
  assign data_err_count = data_err_q;
  assign last_err_count = last_err_q;
  assign keep_err_count = keep_err_q;
  assign frame_done     = frame_done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_stream_check.sv
// Bench for stream_check: table of frame scenarios, hand-written backpressure/clr/reset
// sequences, and random frames checked against a per-frame reference model.
module tb_stream_check;

  logic        clk = 1'b0;
  logic        aresetn, clr;
  logic [31:0] frame_size;
  logic [15:0] ready_rate;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid;
  logic        tready;
  logic [31:0] frame_count;
  logic [15:0] data_err_count, last_err_count, keep_err_count;
  logic        frame_done, error;

  always #5 clk = ~clk;

  stream_check dut (
    .clk(clk), .aresetn(aresetn), .clr(clr), .frame_size(frame_size), .ready_rate(ready_rate),
    .tdata(tdata), .tkeep(tkeep), .tlast(tlast), .tvalid(tvalid), .tready(tready),
    .frame_count(frame_count), .data_err_count(data_err_count), .last_err_count(last_err_count),
    .keep_err_count(keep_err_count), .frame_done(frame_done), .error(error)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_seen = 0;

  always @(posedge clk) cyc++;
  always @(posedge clk) if (frame_done === 1'b1) done_seen++;

  // Reference model: position within the current frame, the length chosen at its start,
  // and whether the rest of an overlong frame is being thrown away.
  int m_frames, m_data, m_last, m_keep, m_done_total;
  int m_pos, m_len;
  bit m_discard;

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_clear();
    m_frames = 0; m_data = 0; m_last = 0; m_keep = 0;
    m_pos = 0; m_len = 1; m_discard = 0;
  endtask

  task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    if (k != 4'hF) m_keep++;
    if (m_discard) begin
      if (l) begin m_discard = 0; m_pos = 0; end
    end else begin
      if (m_pos == 0) m_len = (frame_size == 32'd0) ? 1 : int'(frame_size);
      if (d != 32'(m_pos)) m_data++;
      if (l) begin
        if (m_pos + 1 == m_len) begin m_frames++; m_done_total++; end
        else m_last++;
        m_pos = 0;
      end else if (m_pos + 1 == m_len) begin
        m_last++;
        m_discard = 1;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    chk({name, ".frame_count"}, 64'(frame_count), 64'(m_frames));
    chk({name, ".data_err"}, 64'(data_err_count), 64'(sat(m_data)));
    chk({name, ".last_err"}, 64'(last_err_count), 64'(sat(m_last)));
    chk({name, ".keep_err"}, 64'(keep_err_count), 64'(sat(m_keep)));
    chk({name, ".error"}, 64'(error), 64'((m_data + m_last + m_keep) > 0));
  endtask

  // Called and returns at a negedge; inputs change only there.
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    int w;
    w = 0;
    tvalid = 1'b1; tdata = d; tkeep = k; tlast = l;
    while (tready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (w >= 200) begin
      tests++; fails++;
      $display("FAIL beat_timeout: tready low for %0d cycles, expected high within 200", w);
      tvalid = 1'b0;
      return;
    end
    @(negedge clk);
    tvalid = 1'b0;
    if (clr) model_clear();
    else model_beat(d, k, l);
  endtask

  task automatic send_frame(input int fs, input int nb, input int bad_d, input int bad_k);
    frame_size = 32'(fs);
    for (int i = 0; i < nb; i++)
      send_beat((i == bad_d) ? 32'hDEAD : 32'(i), (i == bad_k) ? 4'h7 : 4'hF, i == nb - 1);
  endtask

  typedef struct {
    int fs; int nb; int bad_d; int bad_k;
    int d_fr; int d_de; int d_le; int d_ke;
  } vec_t;

  vec_t vt[12];

  initial begin
    logic [31:0] f0;
    logic [15:0] de0, le0, ke0;
    logic        pat[16];
    int          highs, first, dt;

    vt[0]  = '{8, 8, -1, -1, 1, 0, 0, 0};
    vt[1]  = '{8, 5, -1, -1, 0, 0, 1, 0};
    vt[2]  = '{8, 8, -1, -1, 1, 0, 0, 0};
    vt[3]  = '{4, 6,  4, -1, 0, 0, 1, 0};
    vt[4]  = '{4, 4, -1, -1, 1, 0, 0, 0};
    vt[5]  = '{16, 16, 3, 9, 1, 1, 0, 1};
    vt[6]  = '{0, 1, -1, -1, 1, 0, 0, 0};
    vt[7]  = '{0, 2, -1, -1, 0, 0, 1, 0};
    vt[8]  = '{1, 1, -1, -1, 1, 0, 0, 0};
    vt[9]  = '{3, 3,  2, -1, 1, 1, 0, 0};
    vt[10] = '{5, 3,  2, -1, 0, 1, 1, 0};
    vt[11] = '{6, 6, -1,  0, 1, 0, 0, 1};

    aresetn = 1'b0; clr = 1'b0; frame_size = 32'd8; ready_rate = 16'd0;
    tdata = 32'd0; tkeep = 4'hF; tlast = 1'b0; tvalid = 1'b0;
    m_done_total = 0;
    model_clear();

    repeat (3) @(negedge clk);
    chk("rst.tready", 64'(tready), 64'd0);
    chk("rst.frame_done", 64'(frame_done), 64'd0);
    check_model("rst");

    aresetn = 1'b1;
    @(negedge clk);
    chk("rst_release.tready", 64'(tready), 64'd1);

    // First good frame, with frame_done width check.
    send_frame(8, 8, -1, -1);
    chk("first.frame_done_hi", 64'(frame_done), 64'd1);
    check_model("first");
    @(negedge clk);
    chk("first.frame_done_lo", 64'(frame_done), 64'd0);

    for (int v = 0; v < 12; v++) begin
      f0 = frame_count; de0 = data_err_count; le0 = last_err_count; ke0 = keep_err_count;
      send_frame(vt[v].fs, vt[v].nb, vt[v].bad_d, vt[v].bad_k);
      chk($sformatf("vec%0d.d_frames", v), 64'(frame_count - f0), 64'(vt[v].d_fr));
      chk($sformatf("vec%0d.d_data", v), 64'(data_err_count - de0), 64'(vt[v].d_de));
      chk($sformatf("vec%0d.d_last", v), 64'(last_err_count - le0), 64'(vt[v].d_le));
      chk($sformatf("vec%0d.d_keep", v), 64'(keep_err_count - ke0), 64'(vt[v].d_ke));
    end
    check_model("table");

    // Backpressure at ready_rate 3: one high cycle in every four.
    ready_rate = 16'd3;
    repeat (8) @(negedge clk);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      pat[i] = tready;
      if (tready === 1'b1) highs++;
      @(negedge clk);
    end
    first = 0;
    for (int i = 3; i >= 0; i--) if (pat[i] === 1'b1) first = i;
    chk("bp.highs_in_16", 64'(highs), 64'd4);
    chk("bp.period4", 64'(pat[first] & pat[first + 4] & pat[first + 8] & pat[first + 12]), 64'd1);

    dt = cyc;
    send_frame(8, 8, -1, -1);
    dt = cyc - dt;
    tests++;
    if (dt < 29 || dt > 32) begin
      fails++;
      $display("FAIL bp.frame_cycles: got %0d, expected 29..32", dt);
    end
    check_model("bp_frame");

    // clr on a beat mid-frame, after some errors have been logged.
    frame_size = 32'd8;
    send_beat(32'd0, 4'hF, 1'b0);
    send_beat(32'd99, 4'hF, 1'b0);
    send_beat(32'd2, 4'h3, 1'b0);
    check_model("pre_clr");
    clr = 1'b1;
    send_beat(32'h55, 4'h0, 1'b0);
    clr = 1'b0;
    check_model("clr");
    send_frame(8, 8, -1, -1);
    check_model("after_clr");

    // Random frames against the model.
    for (int r = 0; r < 40; r++) begin
      int nb;
      ready_rate = 16'($urandom_range(0, 2));
      frame_size = 32'($urandom_range(0, 6));
      nb = $urandom_range(1, 8);
      for (int i = 0; i < nb; i++) begin
        logic [31:0] d;
        logic [3:0]  k;
        d = ($urandom_range(0, 9) == 0) ? 32'($urandom) : 32'(i);
        k = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
        send_beat(d, k, i == nb - 1);
      end
      check_model($sformatf("rand%0d", r));
    end

    // Asynchronous reset mid-frame.
    ready_rate = 16'd0;
    frame_size = 32'd8;
    send_beat(32'd0, 4'hF, 1'b0);
    send_beat(32'd1, 4'hF, 1'b0);
    send_beat(32'd7, 4'h1, 1'b0);
    #2;
    aresetn = 1'b0;
    #1;
    chk("arst.tready", 64'(tready), 64'd0);
    chk("arst.frame_done", 64'(frame_done), 64'd0);
    model_clear();
    check_model("arst");
    @(negedge clk);
    aresetn = 1'b1;
    send_frame(8, 8, -1, -1);
    check_model("after_arst");

    repeat (3) @(negedge clk);
    chk("frame_done_pulses", 64'(done_seen), 64'(m_done_total));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
